// File: rtl/cl_decode_pipe_pkg.sv
// Shared decode definitions: opcode encoding, instruction layout and the
// control bundle produced by the decoder.
package cl_decode_pipe_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 5'd0,
    OP_ADDU = 5'd1,
    OP_SUBU = 5'd2,
    OP_SLLV = 5'd3,
    OP_SRAV = 5'd4,
    OP_SRLV = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOR  = 5'd8,
    OP_SLT  = 5'd9,
    OP_SLTU = 5'd10,
    OP_MOV  = 5'd11,
    OP_JALR = 5'd12,
    OP_LW   = 5'd13,
    OP_LBU  = 5'd14,
    OP_SW   = 5'd15,
    OP_SB   = 5'd16,
    OP_BEQ  = 5'd17,
    OP_BNE  = 5'd18,
    OP_J    = 5'd19
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [10:0] operand;
  } instruction_s;

  typedef struct packed {
    logic is_load;
    logic writes_rf;
    logic is_store;
    logic is_mem;
    logic is_byte;
  } decode_ctrl_s;

endpackage

// File: rtl/cl_decode_pipe_ctrl.sv
// Combinational opcode-class decoder.
// Opcodes outside the listed classes decode to all-zero control.
module cl_decode_ctrl
  import cl_decode_pipe_pkg::*;
(
  input  opcode_e      opcode_i,
  output decode_ctrl_s ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (1'b1)
      (opcode_i inside {OP_ADDU, OP_SUBU, OP_SLLV, OP_SRAV,
                        OP_SRLV, OP_AND, OP_OR, OP_NOR,
                        OP_SLT, OP_SLTU, OP_MOV, OP_JALR}): begin
        ctrl_o.writes_rf = 1'b1;
      end
      (opcode_i == OP_LW): begin
        ctrl_o.is_load   = 1'b1;
        ctrl_o.writes_rf = 1'b1;
        ctrl_o.is_mem    = 1'b1;
      end
      (opcode_i == OP_LBU): begin
        ctrl_o.is_load   = 1'b1;
        ctrl_o.writes_rf = 1'b1;
        ctrl_o.is_mem    = 1'b1;
        ctrl_o.is_byte   = 1'b1;
      end
      (opcode_i == OP_SW): begin
        ctrl_o.is_store = 1'b1;
        ctrl_o.is_mem   = 1'b1;
      end
      (opcode_i == OP_SB): begin
        ctrl_o.is_store = 1'b1;
        ctrl_o.is_mem   = 1'b1;
        ctrl_o.is_byte  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cl_decode_pipe.sv
// Registered decode stage with load-use scoreboard and interlock.
// Optional stall counter output enabled by DECODE_STALL_CNT_EN.
module cl_decode_pipe
  import cl_decode_pipe_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int RF_ADDR_W = 5,
  parameter int LOAD_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [INSTR_W-1:0]   instruction_i,
  input  logic [RF_ADDR_W-1:0] src_a_addr_i,
  input  logic [RF_ADDR_W-1:0] src_b_addr_i,
  input  logic [RF_ADDR_W-1:0] dst_addr_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [INSTR_W-1:0]   instruction_o,
  output logic [RF_ADDR_W-1:0] dst_addr_o,
  output logic                 is_load_op_o,
  output logic                 op_writes_rf_o,
  output logic                 is_store_op_o,
  output logic                 is_mem_op_o,
  output logic                 is_byte_op_o
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  // The stage itself covers the fire cycle, so the oldest slot is the
  // cycle the result becomes forwardable and no longer interlocks.
  localparam logic [LOAD_LAT-1:0] HAZ_MASK = {LOAD_LAT{1'b1}} >> 1;

  decode_ctrl_s dec_ctrl;
  decode_ctrl_s ctrl_d, ctrl_q;

  logic                 out_valid_d, out_valid_q;
  logic [INSTR_W-1:0]   instr_d, instr_q;
  logic [RF_ADDR_W-1:0] dst_d, dst_q;

  logic [LOAD_LAT-1:0]                sb_v_d, sb_v_q;
  logic [LOAD_LAT-1:0][RF_ADDR_W-1:0] sb_a_d, sb_a_q;

  logic hit_a, hit_b, hazard;
  logic in_fire, out_fire;

  cl_decode_ctrl u_ctrl (
    .opcode_i (opcode_e'(instruction_i[INSTR_W-1 -: OPC_W])),
    .ctrl_o   (dec_ctrl)
  );

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_v_q[i] && HAZ_MASK[i]) begin
        hit_a = hit_a | (sb_a_q[i] == src_a_addr_i);
        hit_b = hit_b | (sb_a_q[i] == src_b_addr_i);
      end
    end
    if (out_valid_q && ctrl_q.is_load) begin
      hit_a = hit_a | (dst_q == src_a_addr_i);
      hit_b = hit_b | (dst_q == src_b_addr_i);
    end
    hazard = in_valid_i &&
             ((hit_a && (src_a_addr_i != '0)) ||
              (hit_b && (src_b_addr_i != '0)));
  end

  assign in_ready_o = !reset && (!out_valid_q || out_ready_i) &&
                      !hazard && !flush_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    dst_d       = dst_q;
    ctrl_d      = ctrl_q;
    if (in_fire) begin
      out_valid_d      = 1'b1;
      instr_d          = instruction_i;
      dst_d            = dst_addr_i;
      ctrl_d           = dec_ctrl;
      ctrl_d.writes_rf = dec_ctrl.writes_rf && (dst_addr_i != '0);
    end else if (flush_i || out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    sb_v_d = sb_v_q;
    sb_a_d = sb_a_q;
    for (int i = LOAD_LAT - 1; i > 0; i--) begin
      sb_v_d[i] = sb_v_q[i-1];
      sb_a_d[i] = sb_a_q[i-1];
    end
    sb_v_d[0] = out_fire && ctrl_q.is_load && (dst_q != '0);
    sb_a_d[0] = dst_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      dst_q       <= '0;
      ctrl_q      <= '0;
      sb_v_q      <= '0;
      sb_a_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      dst_q       <= dst_d;
      ctrl_q      <= ctrl_d;
      sb_v_q      <= sb_v_d;
      sb_a_q      <= sb_a_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign instruction_o  = instr_q;
  assign dst_addr_o     = dst_q;
  assign is_load_op_o   = ctrl_q.is_load;
  assign op_writes_rf_o = ctrl_q.writes_rf;
  assign is_store_op_o  = ctrl_q.is_store;
  assign is_mem_op_o    = ctrl_q.is_mem;
  assign is_byte_op_o   = ctrl_q.is_byte;

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
